// File: rtl/axil_reg_pkg.sv
// Shared definitions for the AXI4-Lite register bank and its bus wrapper.
// The response encodings let the wrapper turn rd_err/wr_err into BRESP/RRESP.
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of byte lanes (and therefore strobe bits) in a data word
  function automatic int byte_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axil_reg_bank_if.sv
// Software-side request/response channels of the register bank.
// The master modport is the AXI4-Lite channel FSM side; the slave modport is the bank.
interface axil_reg_bank_if
  import axil_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);

  localparam int STRB_W = byte_count(DATA_W);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_ack;
  logic              wr_err;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_strb,
    input  rd_valid, rd_data, rd_err, wr_ack, wr_err
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_strb,
    output rd_valid, rd_data, rd_err, wr_ack, wr_err
  );

endinterface

// File: rtl/axil_reg_strb_merge.sv
// Next-value logic for one register: hardware update forms the base value,
// then every software-strobed byte is laid on top, so software wins per byte.
module axil_reg_strb_merge
  import axil_reg_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int STRB_W = byte_count(DATA_W)
) (
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [STRB_W-1:0] sw_strb,
  input  logic              sw_en,
  input  logic [DATA_W-1:0] hw_data,
  input  logic              hw_en,
  output logic [DATA_W-1:0] next_val
);

  // Hardware data (or the held value) first, then the software bytes override it
  always_comb begin
    next_val = hw_en ? hw_data : old_val;
    if (sw_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (sw_strb[b]) begin
          next_val[b*8 +: 8] = sw_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axil_reg_bank.sv
// Parametrised register bank with byte strobes, read-only protection,
// a hardware update port and write-first read forwarding.
module axil_reg_bank
  import axil_reg_pkg::*;
#(
  parameter int                         DATA_W    = 32,
  parameter int                         NUM_REGS  = 8,
  parameter int                         ADDR_W    = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0]        RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  axil_reg_bank_if.slave             bus,
  input  logic [NUM_REGS-1:0]        hw_we,
  input  logic [NUM_REGS*DATA_W-1:0] hw_wdata,
  output logic [NUM_REGS*DATA_W-1:0] reg_q
);

  logic [DATA_W-1:0]   regs     [NUM_REGS];
  logic [DATA_W-1:0]   next_val [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] rd_hit;
  logic [DATA_W-1:0]   rd_next;
  logic                wr_legal;

  // Address decode compares the full index, so out-of-range indices never alias
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign wr_hit[i] = (bus.wr_addr == ADDR_W'(i));
    assign rd_hit[i] = (bus.rd_addr == ADDR_W'(i));
    assign reg_q[i*DATA_W +: DATA_W] = regs[i];

    axil_reg_strb_merge #(.DATA_W(DATA_W)) u_merge (
      .old_val  (regs[i]),
      .sw_data  (bus.wr_data),
      .sw_strb  (bus.wr_strb),
      .sw_en    (bus.wr_req && wr_hit[i] && !RO_MASK[i]),
      .hw_data  (hw_wdata[i*DATA_W +: DATA_W]),
      .hw_en    (hw_we[i]),
      .next_val (next_val[i])
    );
  end

  // A write is legal only when it lands on an existing, writable register
  assign wr_legal = |(wr_hit & ~RO_MASK);

  // Read bypass: return the value the addressed register takes at this edge
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_hit[i]) begin
        rd_next = next_val[i];
      end
    end
  end

  // Register storage; reset overrides both software and hardware updates
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end else begin
        regs[i] <= next_val[i];
      end
    end
  end

  // One-cycle responses; rd_data holds until the next accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_err   <= 1'b0;
      bus.wr_ack   <= 1'b0;
      bus.wr_err   <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_req;
      bus.rd_err   <= bus.rd_req && !(|rd_hit);
      if (bus.rd_req) begin
        bus.rd_data <= rd_next;
      end
      bus.wr_ack <= bus.wr_req;
      bus.wr_err <= bus.wr_req && !wr_legal;
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Scoreboard bench for axil_reg_bank with six 32-bit registers, register 5 read-only.
module tb_axil_reg_bank;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 6;
  localparam int ADDR_W   = 3;
  localparam logic [NUM_REGS-1:0] RO_MASK = 6'b100000;
  localparam logic [NUM_REGS*DATA_W-1:0] RESET_VAL = {
    32'h55000005, 32'h00000000, 32'hCAFE0003,
    32'hAABBCCDD, 32'h11111111, 32'h10000000
  };

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rd_exp_t;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REGS-1:0]        hw_we;
  logic [NUM_REGS*DATA_W-1:0] hw_wdata;
  logic [NUM_REGS*DATA_W-1:0] reg_q;

  rd_exp_t rd_q[$];
  logic    wr_q[$];
  int      total = 0;
  int      bad   = 0;

  axil_reg_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  axil_reg_bank #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (ADDR_W),
    .RO_MASK   (RO_MASK),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hw_we    (hw_we),
    .hw_wdata (hw_wdata),
    .reg_q    (reg_q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [191:0] actual, input logic [191:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic setInputs(input logic r, input logic [2:0] ra, input logic w, input logic [2:0] wa,
                           input logic [31:0] wd, input logic [3:0] ws, input logic [5:0] hwe,
                           input logic [31:0] hwv);
    bus.rd_req  = r;
    bus.rd_addr = ra;
    bus.wr_req  = w;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.wr_strb = ws;
    hw_we       = hwe;
    hw_wdata    = {NUM_REGS{hwv}};
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] ra, input logic w, input logic [2:0] wa,
                               input logic [31:0] wd, input logic [3:0] ws, input logic [5:0] hwe,
                               input logic [31:0] hwv);
    @(negedge clk);
    setInputs(r, ra, w, wa, wd, ws, hwe, hwv);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 4'h0, 6'h0, 32'h0);
  endtask

  task automatic expectRead(input logic [31:0] data, input logic err);
    rd_exp_t e;
    e.data = data;
    e.err  = err;
    rd_q.push_back(e);
  endtask

  task automatic expectWrite(input logic err);
    wr_q.push_back(err);
  endtask

  task automatic monitorLoop();
    rd_exp_t e;
    logic    we;
    forever begin
      @(negedge clk);
      if (bus.rd_valid) begin
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rd_valid: got rd_valid=1 data=%0h, required no response", bus.rd_data);
        end else begin
          e = rd_q.pop_front();
          checkOutput("rd_data", bus.rd_data, e.data);
          checkOutput("rd_err", bus.rd_err, e.err);
        end
      end
      if (bus.wr_ack) begin
        if (wr_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_wr_ack: got wr_ack=1, required no response");
        end else begin
          we = wr_q.pop_front();
          checkOutput("wr_err", bus.wr_err, we);
        end
      end
    end
  endtask

  initial begin
    fork
      monitorLoop();
    join_none

    rst = 1'b1;
    setInputs(1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 4'h0, 6'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset_rd_valid", bus.rd_valid, 0);
    checkOutput("reset_wr_ack", bus.wr_ack, 0);
    checkOutput("reset_rd_data", bus.rd_data, 0);
    checkOutput("reset_reg3", reg_q[3*32 +: 32], 32'hCAFE0003);
    checkOutput("reset_reg_q", reg_q, RESET_VAL);
    rst = 1'b0;

    // Read of a reset value, then check the valid pulse and data hold
    applyStimulus(1'b1, 3'd3, 1'b0, 3'd0, 32'h0, 4'h0, 6'h0, 32'h0);
    expectRead(32'hCAFE0003, 1'b0);
    idle();
    idle();
    checkOutput("rd_valid_pulse", bus.rd_valid, 0);
    checkOutput("rd_data_hold", bus.rd_data, 32'hCAFE0003);

    // Byte-strobed write with a same-cycle read of the same register
    applyStimulus(1'b1, 3'd2, 1'b1, 3'd2, 32'h11223344, 4'b0101, 6'h0, 32'h0);
    expectRead(32'hAA22CC44, 1'b0);
    expectWrite(1'b0);
    idle();
    checkOutput("reg2_strobed", reg_q[2*32 +: 32], 32'hAA22CC44);

    // Read-only register ignores software, accepts hardware
    applyStimulus(1'b0, 3'd0, 1'b1, 3'd5, 32'hFFFFFFFF, 4'hF, 6'h0, 32'h0);
    expectWrite(1'b1);
    applyStimulus(1'b1, 3'd5, 1'b0, 3'd0, 32'h0, 4'h0, 6'b100000, 32'h5A5A5A5A);
    checkOutput("reg5_ro_kept", reg_q[5*32 +: 32], 32'h55000005);
    expectRead(32'h5A5A5A5A, 1'b0);
    idle();
    checkOutput("reg5_hw", reg_q[5*32 +: 32], 32'h5A5A5A5A);

    // Collision of hardware and software on register 1 with a read
    applyStimulus(1'b1, 3'd1, 1'b1, 3'd1, 32'hFFFFFFFF, 4'b0011, 6'b000010, 32'h00000000);
    expectRead(32'h0000FFFF, 1'b0);
    expectWrite(1'b0);
    idle();
    checkOutput("reg1_collision", reg_q[1*32 +: 32], 32'h0000FFFF);

    // Out-of-range read and write
    applyStimulus(1'b1, 3'd7, 1'b1, 3'd6, 32'hFFFFFFFF, 4'hF, 6'h0, 32'h0);
    expectRead(32'h0, 1'b1);
    expectWrite(1'b1);
    idle();
    checkOutput("oor_no_change", reg_q,
                {32'h5A5A5A5A, 32'h0, 32'hCAFE0003, 32'hAA22CC44, 32'h0000FFFF, 32'h10000000});

    // All-zero strobe on a legal address
    applyStimulus(1'b0, 3'd0, 1'b1, 3'd4, 32'hFFFFFFFF, 4'h0, 6'h0, 32'h0);
    expectWrite(1'b0);
    idle();
    checkOutput("reg4_zero_strb", reg_q[4*32 +: 32], 32'h0);

    // Back-to-back reads with reset on the third request edge
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 32'h0, 4'h0, 6'h0, 32'h0);
    expectRead(32'h10000000, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b0, 3'd0, 32'h0, 4'h0, 6'h0, 32'h0);
    expectRead(32'h0000FFFF, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b1, 3'd0, 32'hDEADBEEF, 4'hF, 6'b010000, 32'h12345678);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checkOutput("post_reset_rd_valid", bus.rd_valid, 0);
    checkOutput("post_reset_wr_ack", bus.wr_ack, 0);
    checkOutput("post_reset_reg_q", reg_q, RESET_VAL);

    // Normal operation resumes after reset
    applyStimulus(1'b1, 3'd3, 1'b0, 3'd0, 32'h0, 4'h0, 6'h0, 32'h0);
    expectRead(32'hCAFE0003, 1'b0);
    idle();
    idle();
    idle();
    checkOutput("rd_queue_drained", rd_q.size(), 0);
    checkOutput("wr_queue_drained", wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
